// File: rtl/stroke_sequencer.sv
// Steps a glyph segment ROM, registers each segment and offers it downstream over valid/ready.
// Segment valid two cycles after start (plus pen-settle on pen change); holds while ready is low.
module stroke_sequencer #(
    parameter int PEN_SETTLE = 16,
    parameter int CW         = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [4:0]    i_seg_count,
    output logic [4:0]    o_idx,
    output logic          o_rom_en,
    input  logic [CW-1:0] i_rom_start_x,
    input  logic [CW-1:0] i_rom_start_y,
    input  logic [CW-1:0] i_rom_end_x,
    input  logic [CW-1:0] i_rom_end_y,
    input  logic          i_rom_pen_down,
    output logic [CW-1:0] o_seg_start_x,
    output logic [CW-1:0] o_seg_start_y,
    output logic [CW-1:0] o_seg_end_x,
    output logic [CW-1:0] o_seg_end_y,
    output logic          o_seg_pen_down,
    output logic          o_seg_valid,
    input  logic          i_seg_ready,
    output logic          o_pen_state,
    output logic          o_busy,
    output logic          o_done
);

    localparam int            SW          = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((PEN_SETTLE > 0) ? (PEN_SETTLE - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [4:0]    r_idx;
    logic [4:0]    r_cnt_q;
    logic [SW-1:0] r_settle;
    logic [CW-1:0] r_sx;
    logic [CW-1:0] r_sy;
    logic [CW-1:0] r_ex;
    logic [CW-1:0] r_ey;
    logic          r_spd;
    logic          r_pen;

    logic          w_pen_change;
    logic          w_last;
    logic          w_cancel;

    // A zero settle time means pen changes never cost extra cycles.
    assign w_pen_change = (i_rom_pen_down != r_pen) && (PEN_SETTLE > 0);
    assign w_last       = (r_idx == (r_cnt_q - 5'd1));
    assign w_cancel     = i_abort && (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_rom_en    = 1'b0;
        o_seg_valid = 1'b0;
        o_done      = 1'b0;
        o_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = (i_seg_count == 5'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                o_rom_en = 1'b1;
                w_next   = w_pen_change ? S_SETTLE : S_PRESENT;
            end
            S_SETTLE: begin
                if (r_settle == '0) begin
                    w_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                o_seg_valid = 1'b1;
                if (i_seg_ready) begin
                    w_next = w_last ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Abort wins over any handshake in the same cycle.
        if (w_cancel) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx    <= '0;
            r_cnt_q  <= '0;
            r_settle <= '0;
            r_sx     <= '0;
            r_sy     <= '0;
            r_ex     <= '0;
            r_ey     <= '0;
            r_spd    <= 1'b0;
            r_pen    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (i_start) begin
                        r_cnt_q <= i_seg_count;
                    end
                end
                S_FETCH: begin
                    if (!i_abort) begin
                        r_sx  <= i_rom_start_x;
                        r_sy  <= i_rom_start_y;
                        r_ex  <= i_rom_end_x;
                        r_ey  <= i_rom_end_y;
                        r_spd <= i_rom_pen_down;
                        r_pen <= i_rom_pen_down;
                        if (w_pen_change) begin
                            r_settle <= SETTLE_LOAD;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - SW'(1);
                    end
                end
                S_PRESENT: begin
                    if (i_seg_ready && !w_last && !i_abort) begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_FINISH: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
            if (w_cancel) begin
                r_idx <= '0;
            end
        end
    end

    assign o_idx          = r_idx;
    assign o_seg_start_x  = r_sx;
    assign o_seg_start_y  = r_sy;
    assign o_seg_end_x    = r_ex;
    assign o_seg_end_y    = r_ey;
    assign o_seg_pen_down = r_spd;
    assign o_pen_state    = r_pen;

endmodule

// File: doc/stroke_sequencer.md
Name: stroke_sequencer

Overview:
- Drives a glyph segment ROM (for example num5) by stepping `idx` from 0 to `seg_count`-1 with `rom_en` asserted.
- Registers each returned segment and hands it to the downstream line-drawing / plotter stage over a valid/ready handshake.
- Inserts a pen-settle delay whenever the pen state changes between consecutive segments.
- Reports `busy` and a one-cycle `done` per glyph.

Parameters:
- PEN_SETTLE, 16, cycles to wait before presenting a segment whose `pen_down` differs from the current pen state (0 = no wait).
- CW, 8, coordinate width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to draw a glyph; honoured only in IDLE
- abort  in  1  cancel the current glyph
- seg_count  in  5  number of segments in the selected glyph; sampled on accepted start
- idx  out  5  segment index to the ROM
- rom_en  out  1  ROM enable
- rom_start_x, rom_start_y, rom_end_x, rom_end_y  in  CW each  ROM segment coordinates
- rom_pen_down  in  1  ROM pen flag
- seg_start_x, seg_start_y, seg_end_x, seg_end_y  out  CW each  registered segment to downstream
- seg_pen_down  out  1  registered pen flag
- seg_valid  out  1  segment outputs valid
- seg_ready  in  1  downstream accepts the segment
- pen_state  out  1  current committed pen state (1 = down)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last segment is accepted

Behaviour:
- Reset (async, immediate):
  - State = IDLE; `idx`=0; `rom_en`=0.
  - All `seg_*` outputs = 0; `seg_valid`=0; `pen_state`=0 (up); `busy`=0; `done`=0.
  - Settle counter = 0; latched count = 0.
- IDLE:
  - On `start`=1 with `seg_count`>0: latch `seg_count` into `cnt_q`, set `idx`=0, go to FETCH.
  - On `start`=1 with `seg_count`=0: go to FINISH; no ROM access, no segment.
- FETCH (1 cycle):
  - `rom_en`=1; ROM is combinational.
  - At the end of the cycle, register ROM outputs into the `seg_*` registers.
  - If `rom_pen_down` != `pen_state` and PEN_SETTLE>0: load the settle counter with PEN_SETTLE-1 and go to SETTLE.
  - Otherwise go to PRESENT.
- SETTLE:
  - `pen_state` takes the new `seg_pen_down` on entry to SETTLE.
  - The counter decrements each cycle; at 0, go to PRESENT. Total SETTLE dwell = PEN_SETTLE cycles.
- PRESENT:
  - `seg_valid`=1; all `seg_*` outputs are held stable until the handshake.
  - `pen_state` = `seg_pen_down` (already updated in the no-settle case).
  - Transfer occurs on a cycle with `seg_valid` && `seg_ready`. Then:
    - If `idx` == `cnt_q`-1, go to FINISH.
    - Else `idx` <= `idx`+1 and go to FETCH.
  - `seg_valid` deasserts the cycle after the transfer. Back-to-back valid is not required; every segment passes through FETCH.
- FINISH (1 cycle):
  - `done`=1 and `busy`=1 for this cycle, then IDLE.
  - `pen_state` is retained; it is not forced up.
- `rom_en`=1 only in FETCH. `idx` holds its value outside FETCH and returns to 0 in IDLE.
- Latency, no settle: `start` sampled at cycle N → FETCH at N+1 → `seg_valid` high at N+2.
- Abort:
  - `abort`=1 in any non-IDLE state: go to IDLE next cycle; `seg_valid`=0, `done` not pulsed, `idx`=0, `pen_state` retained.
  - `abort` has priority over a simultaneous handshake; that segment counts as not delivered.
- `start` while `busy`=1 is ignored; `seg_count` changes while busy are ignored.
- `seg_ready` high outside PRESENT has no effect.
- `idx` never exceeds `cnt_q`-1; no wrap-around is possible.

Test Plan:
- `seg_count`=7, num5 ROM attached, `seg_ready` tied 1, PEN_SETTLE=4 → 7 segments in order; first = (0,0)->(60,120) pen 0; second = (60,120)->(60,40) pen 1, preceded by a 4-cycle SETTLE; last = (180,40)->(0,0) pen 0, preceded by SETTLE; `done` pulses once; `busy` falls the cycle after `done`.
- Same run with PEN_SETTLE=0 → `seg_valid` at start+2; each following segment valid 2 cycles after the previous transfer; no SETTLE cycles.
- `seg_ready` held low for 10 cycles during segment 2 → `seg_valid` stays high and `seg_*` are unchanged for all 10 cycles; `idx` stays 2; no ROM re-fetch.
- `start` with `seg_count`=0 → `done` pulses 1 cycle after `start`; `rom_en` and `seg_valid` never assert.
- `abort` asserted at `idx`=3 during PRESENT, with `seg_ready`=1 in the same cycle → IDLE next cycle; no `done`; `idx`=0; a following `start` redraws from segment 0.
- Async `rst` pulse mid-SETTLE, between clock edges → all outputs go to their reset values immediately; `start` pulses during `busy` are ignored (checked by counting exactly 7 transfers).
